// File: rtl/ctrl_scan_contador_if.sv
// Request/counter bundle between the floor scheduler and its surroundings.
// The scheduler takes the slave side: it reads the requests and the current
// counter value, and drives the counter controls and its status outputs.
interface ctrl_scan_contador_if #(
    parameter int N_PISOS = 8
);
    logic [N_PISOS-1:0] req;
    logic [3:0]         cnt_q;
    logic               cnt_enb;
    logic               cnt_modo;
    logic [N_PISOS-1:0] pend;
    logic               puerta;
    logic               ocupado;
    logic               error;

    modport master (
        output req, cnt_q,
        input  cnt_enb, cnt_modo, pend, puerta, ocupado, error
    );

    modport slave (
        input  req, cnt_q,
        output cnt_enb, cnt_modo, pend, puerta, ocupado, error
    );
endinterface

// File: rtl/ctrl_scan_contador.sv
// SCAN floor scheduler driving the 4-bit up/down position counter.
// Latches floor requests, keeps moving in the current direction while work
// remains there, steps the counter one floor per enable pulse and holds the
// door open at every served floor. A counter value outside the building, or
// a step that would leave it, parks the block in a sticky fault state.
module ctrl_scan_contador #(
    parameter int N_PISOS  = 8,
    parameter int T_VIAJE  = 2,
    parameter int T_PUERTA = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ctrl_scan_contador_if.slave  bus
);

    localparam logic [7:0] VIAJE_RLD  = 8'(T_VIAJE - 1);
    localparam logic [7:0] PUERTA_RLD = 8'(T_PUERTA - 1);
    localparam logic [4:0] N_LIM      = 5'(N_PISOS);
    localparam logic [3:0] PISO_TOP   = 4'(N_PISOS - 1);

    typedef enum logic [2:0] {
        REPOSO,
        MOVER,
        REVISAR,
        PUERTA,
        FALLA
    } state_t;

    state_t             state_reg;
    logic [7:0]         timer_reg;
    logic [N_PISOS-1:0] pend_reg;
    logic               cnt_enb_reg;
    logic               cnt_modo_reg;
    logic               puerta_reg;
    logic               ocupado_reg;
    logic               error_reg;

    // Per-floor position masks relative to the current counter value.
    logic [N_PISOS-1:0] here_mask;
    logic [N_PISOS-1:0] above_mask;
    logic [N_PISOS-1:0] below_mask;
    logic [N_PISOS-1:0] pr;
    logic [N_PISOS-1:0] serve_mask;

    logic arriba;
    logic abajo;
    logic aqui;
    logic seguir;
    logic fuera;
    logic modo_sel;
    logic step_bad;
    logic enter_puerta;
    logic parte;
    logic arma_enb;
    logic ir_falla;

    genvar gi;
    generate
        for (gi = 0; gi < N_PISOS; gi++) begin : g_piso
            assign here_mask[gi]  = (bus.cnt_q == 4'(gi));
            assign above_mask[gi] = (4'(gi) > bus.cnt_q);
            assign below_mask[gi] = (4'(gi) < bus.cnt_q);
        end
    endgenerate

    // Requests arriving this cycle count as pending for every decision.
    assign pr     = pend_reg | bus.req;
    assign arriba = |(pr & above_mask);
    assign abajo  = |(pr & below_mask);
    assign aqui   = |(pr & here_mask);

    // Continue only while work remains ahead in the direction already held.
    assign seguir = cnt_modo_reg ? arriba : abajo;

    // Counter value outside the building.
    assign fuera = ({1'b0, bus.cnt_q} >= N_LIM);

    // From idle, keep the last direction if it still has work, else reverse.
    assign modo_sel = (state_reg == REPOSO) ? (cnt_modo_reg ? arriba : ~abajo)
                                            : cnt_modo_reg;

    // A step in the chosen direction would leave the building.
    assign step_bad = modo_sel ? (bus.cnt_q == PISO_TOP) : (bus.cnt_q == 4'd0);

    assign enter_puerta = ~fuera & aqui &
                          ((state_reg == REPOSO) || (state_reg == REVISAR));

    // Leaving REPOSO/REVISAR towards MOVER this cycle.
    assign parte = ~aqui & (((state_reg == REPOSO) && (arriba || abajo)) ||
                            ((state_reg == REVISAR) && seguir));

    // The next cycle is MOVER's last one, so the enable pulse is armed now.
    assign arma_enb = ((state_reg == MOVER) && (timer_reg == 8'd1)) ||
                      (parte && (VIAJE_RLD == 8'd0));

    assign ir_falla = fuera || (arma_enb && step_bad);

    // The floor being served absorbs its own request instead of re-queuing it.
    assign serve_mask = ((state_reg == PUERTA) || enter_puerta) ? here_mask
                                                                 : '0;

    // Scheduler state, timers, pending requests and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= REPOSO;
            timer_reg    <= 8'd0;
            pend_reg     <= '0;
            cnt_enb_reg  <= 1'b0;
            cnt_modo_reg <= 1'b1;
            puerta_reg   <= 1'b0;
            ocupado_reg  <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            pend_reg    <= pr & ~serve_mask;
            cnt_enb_reg <= 1'b0;
            if (ir_falla || (state_reg == FALLA)) begin
                state_reg   <= FALLA;
                error_reg   <= 1'b1;
                puerta_reg  <= 1'b0;
                ocupado_reg <= 1'b1;
            end else begin
                case (state_reg)
                    REPOSO: begin
                        if (aqui) begin
                            state_reg   <= PUERTA;
                            timer_reg   <= PUERTA_RLD;
                            puerta_reg  <= 1'b1;
                            ocupado_reg <= 1'b1;
                        end else if (parte) begin
                            state_reg    <= MOVER;
                            timer_reg    <= VIAJE_RLD;
                            cnt_modo_reg <= modo_sel;
                            cnt_enb_reg  <= arma_enb;
                            ocupado_reg  <= 1'b1;
                        end
                    end
                    MOVER: begin
                        if (timer_reg == 8'd0) begin
                            state_reg <= REVISAR;
                        end else begin
                            timer_reg   <= timer_reg - 8'd1;
                            cnt_enb_reg <= arma_enb;
                        end
                    end
                    REVISAR: begin
                        if (aqui) begin
                            state_reg  <= PUERTA;
                            timer_reg  <= PUERTA_RLD;
                            puerta_reg <= 1'b1;
                        end else if (parte) begin
                            state_reg   <= MOVER;
                            timer_reg   <= VIAJE_RLD;
                            cnt_enb_reg <= arma_enb;
                        end else begin
                            state_reg   <= REPOSO;
                            timer_reg   <= 8'd0;
                            ocupado_reg <= 1'b0;
                        end
                    end
                    PUERTA: begin
                        if (|(bus.req & here_mask)) begin
                            timer_reg <= PUERTA_RLD;
                        end else if (timer_reg == 8'd0) begin
                            state_reg   <= REPOSO;
                            puerta_reg  <= 1'b0;
                            ocupado_reg <= 1'b0;
                        end else begin
                            timer_reg <= timer_reg - 8'd1;
                        end
                    end
                    default: begin
                        state_reg   <= FALLA;
                        error_reg   <= 1'b1;
                        puerta_reg  <= 1'b0;
                        ocupado_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.cnt_enb  = cnt_enb_reg;
    assign bus.cnt_modo = cnt_modo_reg;
    assign bus.pend     = pend_reg;
    assign bus.puerta   = puerta_reg;
    assign bus.ocupado  = ocupado_reg;
    assign bus.error    = error_reg;

endmodule

// File: tb/tb_ctrl_scan_contador.sv
// Bench for the SCAN floor scheduler: a behavioural up/down counter closes
// the loop, a monitor logs enable pulses and door openings, and each scenario
// compares what it saw against values derived from the scheduling rules.
module tb_ctrl_scan_contador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'd0;
    logic [3:0] cnt_reg;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Monitor log.
    int stops_q[$];
    int door_len_q[$];
    int pulse_cyc_q[$];
    int n_up, n_dn, enb_viol, modo_viol, pend3_cnt, door_start;
    logic puerta_prev = 1'b0;
    logic enb_prev    = 1'b0;
    logic modo_prev   = 1'b1;

    // Reference model results.
    int exp_stops_q[$];
    int exp_up, exp_dn, exp_pos;
    bit exp_modo;

    ctrl_scan_contador_if #(.N_PISOS(8)) bus ();

    ctrl_scan_contador #(
        .N_PISOS (8),
        .T_VIAJE (2),
        .T_PUERTA(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Position counter the scheduler steers, reset by the same rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= 4'd0;
        else if (bus.cnt_enb)
            cnt_reg <= bus.cnt_modo ? cnt_reg + 4'd1 : cnt_reg - 4'd1;
    end

    assign bus.cnt_q = force_en ? force_val : cnt_reg;

    // Event logger sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.cnt_enb === 1'b1) begin
            pulse_cyc_q.push_back(cyc);
            if (bus.cnt_modo) n_up++; else n_dn++;
            if (enb_prev === 1'b1) enb_viol++;
            if (bus.cnt_modo !== modo_prev) modo_viol++;
        end
        if (bus.pend[3] === 1'b1) pend3_cnt++;
        if (bus.puerta === 1'b1 && puerta_prev !== 1'b1) begin
            stops_q.push_back(int'(bus.cnt_q));
            door_start = cyc;
        end
        if (bus.puerta !== 1'b1 && puerta_prev === 1'b1)
            door_len_q.push_back(cyc - door_start);
        puerta_prev = bus.puerta;
        enb_prev    = bus.cnt_enb;
        modo_prev   = bus.cnt_modo;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SCAN order from a single batch of requests issued while idle.
    function automatic void scan_model(input int start, input bit modo_in,
                                       input logic [7:0] reqs);
        logic [7:0] left;
        int pos;
        int nxt;
        bit dir;
        bit any_up;
        bit any_dn;
        left = reqs;
        pos  = start;
        dir  = modo_in;
        exp_stops_q.delete();
        exp_up = 0;
        exp_dn = 0;
        if (left[pos]) begin
            exp_stops_q.push_back(pos);
            left[pos] = 1'b0;
        end
        while (left != 8'h00) begin
            any_up = 0;
            any_dn = 0;
            for (int i = 0; i < 8; i++) begin
                if (left[i] && i > pos) any_up = 1;
                if (left[i] && i < pos) any_dn = 1;
            end
            if (dir ? !any_up : !any_dn) dir = !dir;
            nxt = pos;
            if (dir) begin
                for (int i = 7; i > pos; i--) if (left[i]) nxt = i;
                exp_up += nxt - pos;
            end else begin
                for (int i = 0; i < pos; i++) if (left[i]) nxt = i;
                exp_dn += pos - nxt;
            end
            pos = nxt;
            exp_stops_q.push_back(pos);
            left[pos] = 1'b0;
        end
        exp_pos  = pos;
        exp_modo = dir;
    endfunction

    task automatic mon_clear();
        stops_q.delete();
        door_len_q.delete();
        pulse_cyc_q.delete();
        n_up = 0; n_dn = 0; enb_viol = 0; modo_viol = 0; pend3_cnt = 0;
    endtask

    task automatic apply_req(input logic [7:0] r);
        @(negedge clk);
        bus.req = r;
        @(negedge clk);
        bus.req = 8'h00;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        while ((bus.ocupado !== 1'b0 || bus.pend !== 8'h00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (n < budget);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        bus.req = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.cnt_enb !== 1'b0) $display("FAIL reset_enb: got %b want 0", bus.cnt_enb); else n_pass++;
        n_total++; if (bus.cnt_modo !== 1'b1) $display("FAIL reset_modo: got %b want 1", bus.cnt_modo); else n_pass++;
        n_total++; if (bus.puerta !== 1'b0) $display("FAIL reset_puerta: got %b want 0", bus.puerta); else n_pass++;
        n_total++; if (bus.ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b want 0", bus.ocupado); else n_pass++;
        n_total++; if (bus.error !== 1'b0) $display("FAIL reset_error: got %b want 0", bus.error); else n_pass++;
        n_total++; if (bus.pend !== 8'h00) $display("FAIL reset_pend: got %b want 0", bus.pend); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.ocupado !== 1'b0) $display("FAIL reset_idle: ocupado got %b want 0", bus.ocupado); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_single_up();
        bit ok;
        int g0, g1;
        mon_clear();
        apply_req(8'b0000_1000);
        wait_idle(300, ok);
        g0 = (pulse_cyc_q.size() >= 3) ? pulse_cyc_q[1] - pulse_cyc_q[0] : -1;
        g1 = (pulse_cyc_q.size() >= 3) ? pulse_cyc_q[2] - pulse_cyc_q[1] : -1;
        n_total++; if (!ok) $display("FAIL up_timeout: idle not reached"); else n_pass++;
        n_total++; if (pulse_cyc_q.size() != 3) $display("FAIL up_pulses: got %0d want 3", pulse_cyc_q.size()); else n_pass++;
        n_total++; if (n_up != 3) $display("FAIL up_dir: up pulses got %0d want 3", n_up); else n_pass++;
        n_total++; if (g0 != 3 || g1 != 3) $display("FAIL up_spacing: got %0d,%0d want 3,3", g0, g1); else n_pass++;
        n_total++; if (bus.cnt_q !== 4'd3) $display("FAIL up_floor: got %0d want 3", bus.cnt_q); else n_pass++;
        n_total++; if (door_len_q.size() != 1 || door_len_q[0] != 4)
            $display("FAIL up_door: got %0d openings len %0d want 1 len 4", door_len_q.size(),
                     (door_len_q.size() > 0) ? door_len_q[0] : -1); else n_pass++;
        n_total++; if (bus.pend !== 8'h00 || bus.ocupado !== 1'b0)
            $display("FAIL up_final: pend %b ocupado %b want 0 0", bus.pend, bus.ocupado); else n_pass++;
        n_total++; if (enb_viol != 0) $display("FAIL up_enb_consec: got %0d want 0", enb_viol); else n_pass++;
        $display("test_single_up: pulses=%0d floor=%0d", pulse_cyc_q.size(), bus.cnt_q);
    endtask

    task automatic test_reopen();
        bit ok;
        mon_clear();
        @(negedge clk);
        bus.req = 8'b0000_1000;
        @(negedge clk);
        bus.req = 8'h00;
        n_total++; if (bus.puerta !== 1'b1) $display("FAIL reopen_open: got %b want 1", bus.puerta); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        bus.req = 8'b0000_1000;
        @(negedge clk);
        bus.req = 8'h00;
        wait_idle(100, ok);
        n_total++; if (!ok) $display("FAIL reopen_timeout: idle not reached"); else n_pass++;
        n_total++; if (door_len_q.size() != 1 || door_len_q[0] != 7)
            $display("FAIL reopen_len: got %0d openings len %0d want 1 len 7", door_len_q.size(),
                     (door_len_q.size() > 0) ? door_len_q[0] : -1); else n_pass++;
        n_total++; if (pend3_cnt != 0) $display("FAIL reopen_pend3: high %0d cycles want 0", pend3_cnt); else n_pass++;
        n_total++; if (pulse_cyc_q.size() != 0) $display("FAIL reopen_pulses: got %0d want 0", pulse_cyc_q.size()); else n_pass++;
        $display("test_reopen: door cycles=%0d", (door_len_q.size() > 0) ? door_len_q[0] : -1);
    endtask

    task automatic test_scan_two();
        bit ok;
        mon_clear();
        apply_req(8'b0010_0010);
        wait_idle(300, ok);
        n_total++; if (!ok) $display("FAIL scan_timeout: idle not reached"); else n_pass++;
        n_total++; if (stops_q.size() != 2 || stops_q[0] != 5 || stops_q[1] != 1)
            $display("FAIL scan_stops: got %0d stops first %0d want 5 then 1", stops_q.size(),
                     (stops_q.size() > 0) ? stops_q[0] : -1); else n_pass++;
        n_total++; if (n_up != 2 || n_dn != 4) $display("FAIL scan_pulses: up %0d down %0d want 2 4", n_up, n_dn); else n_pass++;
        n_total++; if (bus.cnt_modo !== 1'b0) $display("FAIL scan_modo: got %b want 0", bus.cnt_modo); else n_pass++;
        n_total++; if (bus.cnt_q !== 4'd1) $display("FAIL scan_floor: got %0d want 1", bus.cnt_q); else n_pass++;
        n_total++; if (modo_viol != 0) $display("FAIL scan_modo_at_enb: got %0d want 0", modo_viol); else n_pass++;
        $display("test_scan_two: up=%0d down=%0d floor=%0d", n_up, n_dn, bus.cnt_q);
    endtask

    task automatic test_async_reset();
        mon_clear();
        @(negedge clk);
        bus.req = 8'b0000_0001;
        @(negedge clk);
        bus.req = 8'h00;
        n_total++; if (bus.ocupado !== 1'b1 || bus.cnt_modo !== 1'b0)
            $display("FAIL areset_pre: ocupado %b modo %b want 1 0", bus.ocupado, bus.cnt_modo); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.cnt_modo !== 1'b1 || bus.cnt_enb !== 1'b0)
            $display("FAIL areset_ctrl: modo %b enb %b want 1 0", bus.cnt_modo, bus.cnt_enb); else n_pass++;
        n_total++; if (bus.ocupado !== 1'b0 || bus.puerta !== 1'b0 || bus.error !== 1'b0)
            $display("FAIL areset_status: ocupado %b puerta %b error %b want 000", bus.ocupado, bus.puerta, bus.error); else n_pass++;
        n_total++; if (bus.pend !== 8'h00) $display("FAIL areset_pend: got %b want 0", bus.pend); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.pend !== 8'h00 || bus.cnt_q !== 4'd0)
            $display("FAIL areset_after: pend %b floor %0d want 0 0", bus.pend, bus.cnt_q); else n_pass++;
        $display("test_async_reset: pend=%b", bus.pend);
    endtask

    task automatic test_here();
        bit ok;
        mon_clear();
        @(negedge clk);
        bus.req = 8'b0000_0001;
        @(negedge clk);
        bus.req = 8'h00;
        n_total++; if (bus.puerta !== 1'b1) $display("FAIL here_open: got %b want 1", bus.puerta); else n_pass++;
        wait_idle(100, ok);
        n_total++; if (!ok) $display("FAIL here_timeout: idle not reached"); else n_pass++;
        n_total++; if (pulse_cyc_q.size() != 0) $display("FAIL here_pulses: got %0d want 0", pulse_cyc_q.size()); else n_pass++;
        n_total++; if (door_len_q.size() != 1 || door_len_q[0] != 4)
            $display("FAIL here_door: got %0d openings len %0d want 1 len 4", door_len_q.size(),
                     (door_len_q.size() > 0) ? door_len_q[0] : -1); else n_pass++;
        $display("test_here: door cycles=%0d", (door_len_q.size() > 0) ? door_len_q[0] : -1);
    endtask

    task automatic test_random();
        int pos;
        bit modo;
        bit ok;
        int got;
        int bad_len;
        logic [7:0] r;
        pos  = 0;
        modo = 1'b1;
        for (int it = 0; it < 12; it++) begin
            r = 8'($urandom_range(1, 255));
            scan_model(pos, modo, r);
            mon_clear();
            apply_req(r);
            wait_idle(600, ok);
            n_total++; if (!ok) $display("FAIL rand%0d_timeout: idle not reached", it); else n_pass++;
            n_total++; if (stops_q.size() != exp_stops_q.size())
                $display("FAIL rand%0d_nstops: got %0d want %0d", it, stops_q.size(), exp_stops_q.size()); else n_pass++;
            for (int i = 0; i < exp_stops_q.size(); i++) begin
                got = (i < stops_q.size()) ? stops_q[i] : -1;
                n_total++; if (got != exp_stops_q[i])
                    $display("FAIL rand%0d_stop%0d: got %0d want %0d", it, i, got, exp_stops_q[i]); else n_pass++;
            end
            n_total++; if (n_up != exp_up || n_dn != exp_dn)
                $display("FAIL rand%0d_pulses: up %0d down %0d want %0d %0d", it, n_up, n_dn, exp_up, exp_dn); else n_pass++;
            n_total++; if (int'(bus.cnt_q) != exp_pos || bus.cnt_modo !== exp_modo)
                $display("FAIL rand%0d_end: floor %0d modo %b want %0d %b", it, bus.cnt_q, bus.cnt_modo, exp_pos, exp_modo); else n_pass++;
            bad_len = 0;
            foreach (door_len_q[i]) if (door_len_q[i] != 4) bad_len++;
            n_total++; if (bad_len != 0 || door_len_q.size() != exp_stops_q.size())
                $display("FAIL rand%0d_door: %0d bad of %0d want 0 of %0d", it, bad_len, door_len_q.size(), exp_stops_q.size()); else n_pass++;
            n_total++; if (enb_viol != 0 || modo_viol != 0)
                $display("FAIL rand%0d_enb_rules: consec %0d modo %0d want 0 0", it, enb_viol, modo_viol); else n_pass++;
            $display("rand %0d: start=%0d req=%b stops=%0d up=%0d down=%0d", it, pos, r,
                     stops_q.size(), n_up, n_dn);
            pos  = exp_pos;
            modo = exp_modo;
        end
    endtask

    task automatic test_fault();
        int enb_hi;
        int err_lo;
        mon_clear();
        @(negedge clk);
        force_val = 4'd9;
        force_en  = 1'b1;
        #1;
        n_total++; if (bus.error !== 1'b0) $display("FAIL fault_pre: error got %b want 0", bus.error); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.error !== 1'b1) $display("FAIL fault_flag: got %b want 1", bus.error); else n_pass++;
        n_total++; if (bus.ocupado !== 1'b1 || bus.puerta !== 1'b0)
            $display("FAIL fault_status: ocupado %b puerta %b want 1 0", bus.ocupado, bus.puerta); else n_pass++;
        enb_hi = 0;
        err_lo = 0;
        for (int i = 0; i < 20; i++) begin
            bus.req = 8'($urandom);
            if (i == 8) force_en = 1'b0;
            @(negedge clk);
            if (bus.cnt_enb !== 1'b0) enb_hi++;
            if (bus.error !== 1'b1) err_lo++;
        end
        bus.req = 8'h00;
        n_total++; if (enb_hi != 0) $display("FAIL fault_enb: high %0d cycles want 0", enb_hi); else n_pass++;
        n_total++; if (err_lo != 0) $display("FAIL fault_sticky: low %0d cycles want 0", err_lo); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.error !== 1'b0) $display("FAIL fault_reset: got %b want 0", bus.error); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (bus.error !== 1'b0 || bus.ocupado !== 1'b0)
            $display("FAIL fault_after: error %b ocupado %b want 0 0", bus.error, bus.ocupado); else n_pass++;
        $display("test_fault: enb_hi=%0d err_lo=%0d", enb_hi, err_lo);
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_reopen();
        test_scan_two();
        test_async_reset();
        test_here();
        test_random();
        test_fault();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
